// File: rtl/cache_4way_64kb_if.sv
// CPU-side load/store bus of the 4-way cache.
//   master: drives iRd/iWr/iData/iAddr, receives oData/oReady/oHit (CPU, bench)
//   slave : the cache itself
interface cache_4way_64kb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iRd;
    logic              iWr;
    logic [DATA_W-1:0] iData;
    logic [ADDR_W-1:0] iAddr;
    logic [DATA_W-1:0] oData;
    logic              oReady;
    logic              oHit;

    modport master (output iRd, iWr, iData, iAddr, input oData, oReady, oHit);
    modport slave  (input iRd, iWr, iData, iAddr, output oData, oReady, oHit);
endinterface

// File: rtl/cache_4way_64kb.sv
// 64 KB 4-way set-associative write-back / write-allocate cache, one word per line.
// Misses never fetch and evicted lines are dropped (no next-level port yet).
// Ports:
//   clk    rising-edge clock
//   resetn synchronous reset, asserted HIGH despite the name
//   bus    cache_4way_64kb_if.slave: iRd/iWr/iData/iAddr request,
//          oData/oReady/oHit registered one-cycle completion
// Tag word layout: {valid, dirty, tag[17:0]}.

// Simple dual-port RAM: one synchronous write port, one registered read port.
module cache_4way_64kb_ram #(
    parameter int W  = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

module cache_4way_64kb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 18
) (
    input  logic                    clk,
    input  logic                    resetn,
    cache_4way_64kb_if.slave        bus
);
    localparam int TW = TAG_W + 2;

    typedef enum logic {IDLE, LOOKUP} state_t;

    state_t                 state;
    logic [TAG_W-1:0]       latTag;
    logic [INDEX_W-1:0]     latIdx;
    logic [DATA_W-1:0]      latData;
    logic                   latWr;
    logic [1:0]             rrPtr;
    logic                   rdyQ, hitQ;
    logic [DATA_W-1:0]      dataQ;

    logic [3:0][TW-1:0]     tagRd;
    logic [3:0][DATA_W-1:0] dataRd;
    logic [3:0]             hitWay;
    logic [3:0]             wayWe;
    logic                   anyHit, anyInv, wrNow;
    logic [1:0]             victim;
    logic [DATA_W-1:0]      hitData;
    logic [INDEX_W-1:0]     rdIdx;

    // The RAMs read the incoming index every cycle; the value captured on the
    // accepting edge is what LOOKUP sees.
    assign rdIdx = bus.iAddr[INDEX_W+1:2];

    always_comb begin
        hitWay  = '0;
        hitData = '0;
        anyInv  = 1'b0;
        victim  = rrPtr;
        for (int w = 0; w < 4; w++) begin
            if (tagRd[w][TW-1] && tagRd[w][TAG_W-1:0] == latTag) begin
                hitWay[w] = 1'b1;
                hitData   = dataRd[w];
            end
        end
        // Walk downward so the lowest-numbered invalid way wins.
        for (int w = 3; w >= 0; w--) begin
            if (!tagRd[w][TW-1]) begin
                victim = 2'(w);
                anyInv = 1'b1;
            end
        end
    end

    assign anyHit = |hitWay;
    // Reset during LOOKUP suppresses the RAM write.
    assign wrNow  = (state == LOOKUP) && latWr && !resetn;

    always_comb begin
        wayWe = '0;
        for (int w = 0; w < 4; w++)
            wayWe[w] = wrNow && (anyHit ? hitWay[w] : (victim == 2'(w)));
    end

    // Hit and allocate both write {valid, dirty, tag}; on a hit that is the
    // same tag with dirty set.
    cache_4way_64kb_ram #(.W(DATA_W), .AW(INDEX_W)) way0_data_ram (.clk(clk), .we(wayWe[0]), .waddr(latIdx), .wdata(latData), .raddr(rdIdx), .rdata(dataRd[0]));
    cache_4way_64kb_ram #(.W(DATA_W), .AW(INDEX_W)) way1_data_ram (.clk(clk), .we(wayWe[1]), .waddr(latIdx), .wdata(latData), .raddr(rdIdx), .rdata(dataRd[1]));
    cache_4way_64kb_ram #(.W(DATA_W), .AW(INDEX_W)) way2_data_ram (.clk(clk), .we(wayWe[2]), .waddr(latIdx), .wdata(latData), .raddr(rdIdx), .rdata(dataRd[2]));
    cache_4way_64kb_ram #(.W(DATA_W), .AW(INDEX_W)) way3_data_ram (.clk(clk), .we(wayWe[3]), .waddr(latIdx), .wdata(latData), .raddr(rdIdx), .rdata(dataRd[3]));
    cache_4way_64kb_ram #(.W(TW), .AW(INDEX_W)) way0_tag_ram (.clk(clk), .we(wayWe[0]), .waddr(latIdx), .wdata({2'b11, latTag}), .raddr(rdIdx), .rdata(tagRd[0]));
    cache_4way_64kb_ram #(.W(TW), .AW(INDEX_W)) way1_tag_ram (.clk(clk), .we(wayWe[1]), .waddr(latIdx), .wdata({2'b11, latTag}), .raddr(rdIdx), .rdata(tagRd[1]));
    cache_4way_64kb_ram #(.W(TW), .AW(INDEX_W)) way2_tag_ram (.clk(clk), .we(wayWe[2]), .waddr(latIdx), .wdata({2'b11, latTag}), .raddr(rdIdx), .rdata(tagRd[2]));
    cache_4way_64kb_ram #(.W(TW), .AW(INDEX_W)) way3_tag_ram (.clk(clk), .we(wayWe[3]), .waddr(latIdx), .wdata({2'b11, latTag}), .raddr(rdIdx), .rdata(tagRd[3]));

    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= IDLE;
            rdyQ  <= 1'b0;
            hitQ  <= 1'b0;
            dataQ <= '0;
            rrPtr <= 2'd0;
        end else begin
            rdyQ  <= 1'b0;
            hitQ  <= 1'b0;
            dataQ <= '0;
            case (state)
                IDLE: begin
                    if (bus.iRd || bus.iWr) begin
                        latTag  <= bus.iAddr[ADDR_W-1:ADDR_W-TAG_W];
                        latIdx  <= bus.iAddr[INDEX_W+1:2];
                        latData <= bus.iData;
                        latWr   <= bus.iWr;   // rd+wr together counts as a write
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    rdyQ  <= 1'b1;
                    hitQ  <= anyHit;
                    state <= IDLE;
                    if (!latWr && anyHit) dataQ <= hitData;
                    // Pointer only moves when it actually chose the victim.
                    if (latWr && !anyHit && !anyInv) rrPtr <= rrPtr + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oReady = rdyQ;
    assign bus.oHit   = hitQ;
    assign bus.oData  = dataQ;

    logic [5:0] unusedBits;
    assign unusedBits = {bus.iAddr[1:0], tagRd[0][TAG_W], tagRd[1][TAG_W],
                         tagRd[2][TAG_W], tagRd[3][TAG_W]};
endmodule

// File: tb/tb_cache_4way_64kb.sv
module tb_cache_4way_64kb;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cache_4way_64kb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_4way_64kb dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        expHit;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the completion pulse.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic rdy, output logic hit, output logic [31:0] q);
        @(negedge clk);
        bus.iRd = rd; bus.iWr = wr; bus.iAddr = a; bus.iData = d;
        @(negedge clk);
        bus.iRd = 1'b0; bus.iWr = 1'b0;
        rdy = 1'b0; hit = 1'b0; q = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.oReady) begin
                rdy = 1'b1; hit = bus.oHit; q = bus.oData;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic reqChk(input string name, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic expHit, input logic [31:0] expData);
        logic rdy, hit;
        logic [31:0] q;
        req(rd, wr, a, d, rdy, hit, q);
        chk({name, "_ready"}, 32'(rdy), 32'd1);
        chk({name, "_hit"}, 32'(hit), 32'(expHit));
        chk({name, "_data"}, q, expData);
    endtask

    initial begin
        int pulses;
        logic [31:0] firstData;

        bus.iRd = 1'b0; bus.iWr = 1'b0; bus.iAddr = '0; bus.iData = '0;
        for (int i = 0; i < 4096; i++) begin
            dut.way0_tag_ram.mem[i] = '0;  dut.way0_data_ram.mem[i] = '0;
            dut.way1_tag_ram.mem[i] = '0;  dut.way1_data_ram.mem[i] = '0;
            dut.way2_tag_ram.mem[i] = '0;  dut.way2_data_ram.mem[i] = '0;
            dut.way3_tag_ram.mem[i] = '0;  dut.way3_data_ram.mem[i] = '0;
        end

        //          rd    wr    addr          data          hit   rdData
        vecs[0] = '{1'b0, 1'b1, 32'hFDEF_1000, 32'h1234_5678, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'hFDEF_1000, 32'h0,         1'b1, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_4040, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_8040, 32'h0,         1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_4040, 32'hCAFE_0001, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_4040, 32'h0,         1'b1, 32'hCAFE_0001};

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.oReady), 32'd0);
        chk("reset_hit", 32'(bus.oHit), 32'd0);
        chk("reset_data", bus.oData, 32'd0);
        resetn = 1'b0;

        // Clean line in way2, index 0x10, tag 1 (survived reset).
        dut.way2_tag_ram.mem[12'h010]  = {2'b10, 18'h00001};
        dut.way2_data_ram.mem[12'h010] = 32'hDEAD_BEEF;

        for (int i = 0; i < 6; i++) begin
            reqChk($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].expHit, vecs[i].expData);
            if (i == 0) begin
                chk("alloc_way0_tag", 32'(dut.way0_tag_ram.mem[12'h400]), 32'({2'b11, 18'h3F7BC}));
                chk("alloc_way0_data", dut.way0_data_ram.mem[12'h400], 32'h1234_5678);
            end
            if (i == 4) begin
                chk("whit_tag_dirty", 32'(dut.way2_tag_ram.mem[12'h010]), 32'({2'b11, 18'h00001}));
                chk("whit_data", dut.way2_data_ram.mem[12'h010], 32'hCAFE_0001);
            end
        end

        // Full set at 0x400: round-robin victims, pointer starts at 0.
        dut.way0_tag_ram.mem[12'h400] = {2'b10, 18'h00100}; dut.way0_data_ram.mem[12'h400] = 32'h1000;
        dut.way1_tag_ram.mem[12'h400] = {2'b10, 18'h00101}; dut.way1_data_ram.mem[12'h400] = 32'h1001;
        dut.way2_tag_ram.mem[12'h400] = {2'b10, 18'h00102}; dut.way2_data_ram.mem[12'h400] = 32'h1002;
        dut.way3_tag_ram.mem[12'h400] = {2'b10, 18'h00103}; dut.way3_data_ram.mem[12'h400] = 32'h1003;
        reqChk("rr_miss1", 1'b0, 1'b1, 32'hFDEF_1000, 32'hAAAA_0000, 1'b0, 32'h0);
        chk("rr1_way0_tag", 32'(dut.way0_tag_ram.mem[12'h400]), 32'({2'b11, 18'h3F7BC}));
        chk("rr1_way0_data", dut.way0_data_ram.mem[12'h400], 32'hAAAA_0000);
        chk("rr1_way1_tag", 32'(dut.way1_tag_ram.mem[12'h400]), 32'({2'b10, 18'h00101}));
        reqChk("rr_miss2", 1'b0, 1'b1, 32'hFDEF_5000, 32'hBBBB_0000, 1'b0, 32'h0);
        chk("rr2_way1_tag", 32'(dut.way1_tag_ram.mem[12'h400]), 32'({2'b11, 18'h3F7BD}));
        chk("rr2_way1_data", dut.way1_data_ram.mem[12'h400], 32'hBBBB_0000);
        chk("rr2_way0_data", dut.way0_data_ram.mem[12'h400], 32'hAAAA_0000);
        chk("rr2_way2_tag", 32'(dut.way2_tag_ram.mem[12'h400]), 32'({2'b10, 18'h00102}));
        reqChk("rr_readback", 1'b1, 1'b0, 32'hFDEF_5000, 32'h0, 1'b1, 32'hBBBB_0000);

        // Request presented during LOOKUP is dropped: exactly one pulse.
        @(negedge clk);
        bus.iRd = 1'b1; bus.iWr = 1'b0; bus.iAddr = 32'h0000_4040;
        @(negedge clk);
        bus.iRd = 1'b0; bus.iWr = 1'b1; bus.iAddr = 32'hFDEF_5000; bus.iData = 32'h7777_7777;
        @(negedge clk);
        bus.iWr = 1'b0;
        pulses = 0; firstData = '0;
        for (int i = 0; i < 6; i++) begin
            if (bus.oReady) begin
                if (pulses == 0) firstData = bus.oData;
                pulses++;
            end
            @(negedge clk);
        end
        chk("ignore_pulses", 32'(pulses), 32'd1);
        chk("ignore_rdata", firstData, 32'hCAFE_0001);
        chk("ignore_noWrite", dut.way1_data_ram.mem[12'h400], 32'hBBBB_0000);

        // Reset lands on the LOOKUP cycle of a write.
        @(negedge clk);
        bus.iWr = 1'b1; bus.iAddr = 32'h0000_0100; bus.iData = 32'h5555_5555;
        @(negedge clk);
        bus.iWr = 1'b0; resetn = 1'b1;
        @(negedge clk);
        chk("rstLk_ready", 32'(bus.oReady), 32'd0);
        chk("rstLk_tag", 32'(dut.way0_tag_ram.mem[12'h040]), 32'd0);
        chk("rstLk_data", dut.way0_data_ram.mem[12'h040], 32'd0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstLk_quiet", 32'(bus.oReady), 32'd0);
        reqChk("rstLk_readMiss", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
